// File: rtl/pipe_ctrl_if.sv
// Pipeline status and control bundle between the pipeline stages and pipe_ctrl.
// The master side reports ID/EX/MEM status; the slave side (pipe_ctrl) drives controls.
interface pipe_ctrl_if;
    logic [4:0]  id_ra_addr;
    logic [4:0]  id_rb_addr;
    logic        id_uses_ra;
    logic        id_uses_rb;
    logic        id_is_jump;
    logic        ex_do_dm_read;
    logic [4:0]  ex_write_reg_addr;
    logic        ex_branch_taken;
    logic        mem_alu_overflow;
    logic        do_flush_REG1;
    logic        do_flush_REG2;
    logic        do_flush_REG3;
    logic        do_flush_REG4;
    logic        do_hazard;
    logic        pc_hold;
    logic [1:0]  pc_select;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    modport master (
        output id_ra_addr, id_rb_addr, id_uses_ra, id_uses_rb, id_is_jump,
        output ex_do_dm_read, ex_write_reg_addr, ex_branch_taken, mem_alu_overflow,
        input  do_flush_REG1, do_flush_REG2, do_flush_REG3, do_flush_REG4,
        input  do_hazard, pc_hold, pc_select, stall_count, flush_count
    );

    modport slave (
        input  id_ra_addr, id_rb_addr, id_uses_ra, id_uses_rb, id_is_jump,
        input  ex_do_dm_read, ex_write_reg_addr, ex_branch_taken, mem_alu_overflow,
        output do_flush_REG1, do_flush_REG2, do_flush_REG3, do_flush_REG4,
        output do_hazard, pc_hold, pc_select, stall_count, flush_count
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: load-use stalls, jump/branch redirects, overflow
// traps with fetch drain, and saturating stall/flush event counters.
module pipe_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int TRAP_DRAIN_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    pipe_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        TRAP_DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] SEL_SEQ  = 2'b00;
    localparam logic [1:0] SEL_JUMP = 2'b01;
    localparam logic [1:0] SEL_BR   = 2'b10;
    localparam logic [1:0] SEL_TRAP = 2'b11;

    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0] DRAIN_RELOAD = 3'(TRAP_DRAIN_CYCLES);
    localparam bit         MULTI_STALL  = (LOAD_STALL_CYCLES > 1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    logic        lu;
    logic        flush1, flush2, flush3, flush4;
    logic        hazard;
    logic        hold;
    logic [1:0]  sel;
    logic        redirect;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    always_comb begin
        lu = bus.ex_do_dm_read && (bus.ex_write_reg_addr != 5'd0) &&
             ((bus.id_uses_ra && (bus.id_ra_addr == bus.ex_write_reg_addr)) ||
              (bus.id_uses_rb && (bus.id_rb_addr == bus.ex_write_reg_addr)));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        flush1   = 1'b0;
        flush2   = 1'b0;
        flush3   = 1'b0;
        flush4   = 1'b0;
        hazard   = 1'b0;
        hold     = 1'b0;
        sel      = SEL_SEQ;
        redirect = 1'b0;

        unique case (state_q)
            RUN: begin
                if (bus.mem_alu_overflow) begin
                    {flush1, flush2, flush3, flush4} = 4'b1111;
                    sel      = SEL_TRAP;
                    cnt_d    = DRAIN_RELOAD;
                    state_d  = TRAP_DRAIN;
                    redirect = 1'b1;
                end else if (bus.ex_branch_taken) begin
                    {flush1, flush2} = 2'b11;
                    sel      = SEL_BR;
                    redirect = 1'b1;
                end else if (lu) begin
                    // A jump stuck behind a load-use waits in ID until the stall clears.
                    hazard = 1'b1;
                    hold   = 1'b1;
                    if (MULTI_STALL) begin
                        cnt_d   = STALL_RELOAD;
                        state_d = LOAD_STALL;
                    end
                end else if (bus.id_is_jump) begin
                    flush1   = 1'b1;
                    sel      = SEL_JUMP;
                    redirect = 1'b1;
                end
            end
            LOAD_STALL: begin
                if (bus.mem_alu_overflow) begin
                    {flush1, flush2, flush3, flush4} = 4'b1111;
                    sel      = SEL_TRAP;
                    cnt_d    = DRAIN_RELOAD;
                    state_d  = TRAP_DRAIN;
                    redirect = 1'b1;
                end else if (bus.ex_branch_taken) begin
                    {flush1, flush2} = 2'b11;
                    sel      = SEL_BR;
                    state_d  = RUN;
                    redirect = 1'b1;
                end else begin
                    hazard = 1'b1;
                    hold   = 1'b1;
                    cnt_d  = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = RUN;
                    end
                end
            end
            TRAP_DRAIN: begin
                // Fetch stays quiesced; every status input is ignored until the drain ends.
                flush1 = 1'b1;
                hold   = 1'b1;
                cnt_d  = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end
        endcase

        if (reset) begin
            {flush1, flush2, flush3, flush4} = 4'b1111;
            hazard   = 1'b0;
            hold     = 1'b1;
            sel      = SEL_SEQ;
            redirect = 1'b0;
            state_d  = RUN;
            cnt_d    = 3'd0;
        end
    end

    always_comb begin
        stall_count_d = hazard   ? sat_inc(stall_count_q) : stall_count_q;
        flush_count_d = redirect ? sat_inc(flush_count_q) : flush_count_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= RUN;
            cnt_q         <= 3'd0;
            stall_count_q <= 16'd0;
            flush_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign bus.do_flush_REG1 = flush1;
    assign bus.do_flush_REG2 = flush2;
    assign bus.do_flush_REG3 = flush3;
    assign bus.do_flush_REG4 = flush4;
    assign bus.do_hazard     = hazard;
    assign bus.pc_hold       = hold;
    assign bus.pc_select     = sel;
    assign bus.stall_count   = stall_count_q;
    assign bus.flush_count   = flush_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: single-cycle stall instance (A) and three-cycle
// stall instance (B) share one stimulus stream; each is checked against its own vectors.
module tb_pipe_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic [4:0] ra, rb, wr;
    logic       ua, ub, jmp, rd, br, ovf;

    int checks = 0;
    int errors = 0;

    pipe_ctrl_if ifa();
    pipe_ctrl_if ifb();

    assign ifa.id_ra_addr        = ra;
    assign ifa.id_rb_addr        = rb;
    assign ifa.id_uses_ra        = ua;
    assign ifa.id_uses_rb        = ub;
    assign ifa.id_is_jump        = jmp;
    assign ifa.ex_do_dm_read     = rd;
    assign ifa.ex_write_reg_addr = wr;
    assign ifa.ex_branch_taken   = br;
    assign ifa.mem_alu_overflow  = ovf;

    assign ifb.id_ra_addr        = ra;
    assign ifb.id_rb_addr        = rb;
    assign ifb.id_uses_ra        = ua;
    assign ifb.id_uses_rb        = ub;
    assign ifb.id_is_jump        = jmp;
    assign ifb.ex_do_dm_read     = rd;
    assign ifb.ex_write_reg_addr = wr;
    assign ifb.ex_branch_taken   = br;
    assign ifb.mem_alu_overflow  = ovf;

    pipe_ctrl #(.LOAD_STALL_CYCLES(1), .TRAP_DRAIN_CYCLES(2)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (ifa)
    );

    pipe_ctrl #(.LOAD_STALL_CYCLES(3), .TRAP_DRAIN_CYCLES(2)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (ifb)
    );

    always #5 clock = ~clock;

    // {flush1, flush2, flush3, flush4, do_hazard, pc_hold, pc_select[1:0]}
    wire [7:0] outs_a = {ifa.do_flush_REG1, ifa.do_flush_REG2, ifa.do_flush_REG3,
                         ifa.do_flush_REG4, ifa.do_hazard, ifa.pc_hold, ifa.pc_select};
    wire [7:0] outs_b = {ifb.do_flush_REG1, ifb.do_flush_REG2, ifb.do_flush_REG3,
                         ifb.do_flush_REG4, ifb.do_hazard, ifb.pc_hold, ifb.pc_select};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ra = 5'd0; rb = 5'd0; wr = 5'd0;
        ua = 1'b0; ub = 1'b0; jmp = 1'b0; rd = 1'b0; br = 1'b0; ovf = 1'b0;
    endtask

    task automatic load_use();
        idle();
        rd = 1'b1; wr = 5'd5; ua = 1'b1; ra = 5'd5;
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 ns later.
    task automatic next_cycle();
        @(negedge clock);
    endtask

    initial begin
        idle();
        reset = 1'b1;

        next_cycle(); #1;
        check("a_reset_outs", 32'(outs_a), 32'h000000F4);
        check("b_reset_outs", 32'(outs_b), 32'h000000F4);
        next_cycle(); #1;
        check("a_reset_stall", 32'(ifa.stall_count), 32'd0);
        check("a_reset_flush", 32'(ifa.flush_count), 32'd0);

        next_cycle(); reset = 1'b0; idle(); #1;
        check("a_idle_outs", 32'(outs_a), 32'h00);

        next_cycle(); load_use(); #1;
        check("a_lu_outs", 32'(outs_a), 32'h0C);
        next_cycle(); idle(); #1;
        check("a_lu_done", 32'(outs_a), 32'h00);
        check("a_lu_stall", 32'(ifa.stall_count), 32'd1);

        next_cycle(); idle(); rd = 1'b1; ua = 1'b1; #1;
        check("a_r0_outs", 32'(outs_a), 32'h00);
        next_cycle(); idle(); rd = 1'b1; wr = 5'd5; ra = 5'd5; #1;
        check("a_unused_outs", 32'(outs_a), 32'h00);
        next_cycle(); idle(); #1;
        check("a_r0_stall", 32'(ifa.stall_count), 32'd1);

        next_cycle(); idle(); rd = 1'b1; wr = 5'd7; ub = 1'b1; rb = 5'd7; #1;
        check("a_lu_rb_outs", 32'(outs_a), 32'h0C);

        next_cycle(); load_use(); br = 1'b1; #1;
        check("a_br_lu_outs", 32'(outs_a), 32'hC2);
        next_cycle(); idle(); jmp = 1'b1; #1;
        check("a_br_flush", 32'(ifa.flush_count), 32'd1);
        check("a_br_stall", 32'(ifa.stall_count), 32'd2);
        check("a_jump_outs", 32'(outs_a), 32'h81);

        next_cycle(); load_use(); jmp = 1'b1; #1;
        check("a_jump_lu_outs", 32'(outs_a), 32'h0C);
        next_cycle(); idle(); jmp = 1'b1; #1;
        check("a_jump_after_outs", 32'(outs_a), 32'h81);
        check("a_jump_after_flush", 32'(ifa.flush_count), 32'd2);

        next_cycle(); idle(); ovf = 1'b1; #1;
        check("a_trap_c0", 32'(outs_a), 32'hF3);
        next_cycle(); idle(); jmp = 1'b1; ovf = 1'b1; #1;
        check("a_trap_c1", 32'(outs_a), 32'h84);
        next_cycle(); idle(); load_use(); jmp = 1'b1; #1;
        check("a_trap_c2", 32'(outs_a), 32'h84);
        next_cycle(); idle(); #1;
        check("a_trap_c3", 32'(outs_a), 32'h00);
        check("a_trap_flush", 32'(ifa.flush_count), 32'd4);
        check("a_trap_stall", 32'(ifa.stall_count), 32'd3);

        // 3 stalls so far; 65532 more reach the ceiling.
        next_cycle(); load_use();
        repeat (65532) next_cycle();
        #1;
        check("a_sat_reach", 32'(ifa.stall_count), 32'hFFFF);
        next_cycle(); #1;
        check("a_sat_hold_outs", 32'(outs_a), 32'h0C);
        check("a_sat_hold", 32'(ifa.stall_count), 32'hFFFF);

        next_cycle(); idle(); ovf = 1'b1; #1;
        check("a_rst_trap_c0", 32'(outs_a), 32'hF3);
        next_cycle(); idle(); reset = 1'b1; #1;
        check("a_rst_mid_drain", 32'(outs_a), 32'hF4);
        next_cycle(); reset = 1'b0; idle(); jmp = 1'b1; #1;
        check("a_rst_run_outs", 32'(outs_a), 32'h81);
        check("a_rst_stall", 32'(ifa.stall_count), 32'd0);
        check("a_rst_flush", 32'(ifa.flush_count), 32'd0);

        // Reset the shared counters before the multi-cycle-stall instance is scored.
        next_cycle(); idle(); reset = 1'b1;
        next_cycle(); reset = 1'b0; #1;
        check("b_clean_stall", 32'(ifb.stall_count), 32'd0);

        next_cycle(); load_use(); #1;
        check("b_abort_c0", 32'(outs_b), 32'h0C);
        next_cycle(); idle(); ovf = 1'b1; #1;
        check("b_abort_trap", 32'(outs_b), 32'hF3);
        next_cycle(); idle(); #1;
        check("b_abort_d1", 32'(outs_b), 32'h84);
        next_cycle(); idle(); #1;
        check("b_abort_d2", 32'(outs_b), 32'h84);
        next_cycle(); idle(); #1;
        check("b_abort_run", 32'(outs_b), 32'h00);
        check("b_abort_stall", 32'(ifb.stall_count), 32'd1);
        check("b_abort_flush", 32'(ifb.flush_count), 32'd1);

        next_cycle(); load_use(); #1;
        check("b_br_c0", 32'(outs_b), 32'h0C);
        next_cycle(); idle(); br = 1'b1; #1;
        check("b_br_abort", 32'(outs_b), 32'hC2);
        next_cycle(); idle(); #1;
        check("b_br_run", 32'(outs_b), 32'h00);
        check("b_br_stall", 32'(ifb.stall_count), 32'd2);
        check("b_br_flush", 32'(ifb.flush_count), 32'd2);

        next_cycle(); load_use(); #1;
        check("b_stall_c0", 32'(outs_b), 32'h0C);
        next_cycle(); idle(); #1;
        check("b_stall_c1", 32'(outs_b), 32'h0C);
        next_cycle(); idle(); #1;
        check("b_stall_c2", 32'(outs_b), 32'h0C);
        next_cycle(); idle(); #1;
        check("b_stall_end", 32'(outs_b), 32'h00);
        check("b_stall_count", 32'(ifb.stall_count), 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
